fu_cdb_tx_queue: RTL and testbench

Per-functional-unit completion queue on the transmit side of the CDB. Completed results from one functional unit are buffered here; the queue presents its oldest entry as one request lane of the CDB arbiter and pops it when the arbiter grants that lane. It absorbs cycles where more units complete than there are CDB ways, and provides backpressure to the functional unit when full.

---
 rtl/fu_cdb_tx_queue_pkg.sv | 18 +
 rtl/fu_cdb_tx_queue_if.sv | 41 ++++
 rtl/fu_cdb_tx_queue.sv | 91 +++++++++
 tb/tb_fu_cdb_tx_queue.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_cdb_tx_queue_pkg.sv
// Shared CDB packet definition used by the functional units, their transmit
// queues and the CDB arbiter.
package cdb_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PRF   = 64;
  localparam int unsigned ROB   = 32;
  localparam int unsigned PRF_W = $clog2(PRF);
  localparam int unsigned ROB_W = $clog2(ROB);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [PRF_W-1:0] prf_idx;
    logic [ROB_W-1:0] rob_idx;
    logic             direction;
    logic [XLEN-1:0]  target;
    logic             reg_write;
  } cdb_packet_t;
endpackage

// File: rtl/fu_cdb_tx_queue_if.sv
// Handshake bundle between a functional unit / CDB arbiter (master) and its
// transmit queue (slave).
interface fu_cdb_tx_queue_if
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  logic                     enq_valid;
  logic [XLEN-1:0]          enq_Data;
  logic [PRF_W-1:0]         enq_PRF_idx;
  logic [ROB_W-1:0]         enq_ROB_idx;
  logic                     enq_direction;
  logic [XLEN-1:0]          enq_target;
  logic                     enq_reg_write;
  logic                     enq_ready;
  logic                     CDB_valid_out;
  logic [XLEN-1:0]          CDB_Data_out;
  logic [PRF_W-1:0]         CDB_PRF_idx_out;
  logic [ROB_W-1:0]         CDB_ROB_idx_out;
  logic                     CDB_direction_out;
  logic [XLEN-1:0]          CDB_target_out;
  logic                     CDB_reg_write_out;
  logic                     CDB_grant_in;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output enq_valid, enq_Data, enq_PRF_idx, enq_ROB_idx, enq_direction,
           enq_target, enq_reg_write, CDB_grant_in,
    input  enq_ready, CDB_valid_out, CDB_Data_out, CDB_PRF_idx_out,
           CDB_ROB_idx_out, CDB_direction_out, CDB_target_out,
           CDB_reg_write_out, count
  );

  modport slave (
    input  enq_valid, enq_Data, enq_PRF_idx, enq_ROB_idx, enq_direction,
           enq_target, enq_reg_write, CDB_grant_in,
    output enq_ready, CDB_valid_out, CDB_Data_out, CDB_PRF_idx_out,
           CDB_ROB_idx_out, CDB_direction_out, CDB_target_out,
           CDB_reg_write_out, count
  );
endinterface

// File: rtl/fu_cdb_tx_queue.sv
// Per-functional-unit CDB transmit FIFO: buffers completed results and offers
// the oldest one as a request lane to the CDB arbiter.
module fu_cdb_tx_queue
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  input logic              squash,
  fu_cdb_tx_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};

  cdb_packet_t       mem_q [DEPTH-1:0];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              enq_fire;
  logic              deq_fire;
  logic              head_valid;
  cdb_packet_t       enq_pkt;
  cdb_packet_t       head_pkt;

  // Ready depends only on registered occupancy, never on the grant.
  assign head_valid = (count_q != EMPTY_CNT);
  assign enq_fire   = bus.enq_valid && (count_q != FULL_CNT);
  assign deq_fire   = bus.CDB_grant_in && head_valid;

  assign enq_pkt = '{data:      bus.enq_Data,
                     prf_idx:   bus.enq_PRF_idx,
                     rob_idx:   bus.enq_ROB_idx,
                     direction: bus.enq_direction,
                     target:    bus.enq_target,
                     reg_write: bus.enq_reg_write};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = EMPTY_CNT;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      else          tail_d = tail_q;
      if (deq_fire) head_d = head_q + PTR_W'(1);
      else          head_d = head_q;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= EMPTY_CNT;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: every read is gated by occupancy.
  always_ff @(posedge clock) begin
    if (enq_fire && !squash && !reset) begin
      mem_q[tail_q] <= enq_pkt;
    end
  end

  assign head_pkt = head_valid ? mem_q[head_q] : {$bits(cdb_packet_t){1'b0}};

  assign bus.enq_ready         = (count_q != FULL_CNT);
  assign bus.CDB_valid_out     = head_valid;
  assign bus.CDB_Data_out      = head_pkt.data;
  assign bus.CDB_PRF_idx_out   = head_pkt.prf_idx;
  assign bus.CDB_ROB_idx_out   = head_pkt.rob_idx;
  assign bus.CDB_direction_out = head_pkt.direction;
  assign bus.CDB_target_out    = head_pkt.target;
  assign bus.CDB_reg_write_out = head_pkt.reg_write;
  assign bus.count             = count_q;
endmodule

// File: tb/tb_fu_cdb_tx_queue.sv
// Randomized bench for fu_cdb_tx_queue against a queue-based reference model.
module tb_fu_cdb_tx_queue;
  import cdb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset;
  logic squash;

  fu_cdb_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  fu_cdb_tx_queue #(.DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_tests   = 0;
  int n_fail    = 0;
  int proto_err = 0;
  cdb_packet_t mq[$];
  cdb_packet_t cur_pkt;

  function automatic cdb_packet_t rand_pkt(input int rob);
    cdb_packet_t p;
    p.data      = $urandom;
    p.prf_idx   = PRF_W'($urandom);
    p.rob_idx   = ROB_W'(rob);
    p.direction = 1'($urandom);
    p.target    = $urandom;
    p.reg_write = 1'($urandom);
    return p;
  endfunction

  task automatic set_enq(input logic v, input cdb_packet_t p);
    cur_pkt           = p;
    bus.enq_valid     = v;
    bus.enq_Data      = p.data;
    bus.enq_PRF_idx   = p.prf_idx;
    bus.enq_ROB_idx   = p.rob_idx;
    bus.enq_direction = p.direction;
    bus.enq_target    = p.target;
    bus.enq_reg_write = p.reg_write;
  endtask

  function automatic cdb_packet_t dut_head();
    return '{data: bus.CDB_Data_out, prf_idx: bus.CDB_PRF_idx_out,
             rob_idx: bus.CDB_ROB_idx_out, direction: bus.CDB_direction_out,
             target: bus.CDB_target_out, reg_write: bus.CDB_reg_write_out};
  endfunction

  function automatic cdb_packet_t exp_head();
    cdb_packet_t z;
    z = {$bits(cdb_packet_t){1'b0}};
    return (mq.size() != 0) ? mq[0] : z;
  endfunction

  function automatic logic [CNT_W+1:0] exp_status();
    return {mq.size() != 0, mq.size() != DEPTH, CNT_W'(mq.size())};
  endfunction

  // One clock edge; the model applies the same inputs the DUT samples.
  task automatic tick();
    bit enq_ok, deq_ok;
    @(posedge clock);
    if (reset || squash) begin
      mq.delete();
    end else begin
      enq_ok = bus.enq_valid && (mq.size() < DEPTH);
      deq_ok = bus.CDB_grant_in && (mq.size() > 0);
      if (bus.CDB_grant_in && mq.size() == 0) begin
        proto_err++;
        $display("[TB] protocol error: grant while queue empty at %0t", $time);
      end
      if (deq_ok) void'(mq.pop_front());
      if (enq_ok) mq.push_back(cur_pkt);
    end
    #1;
  endtask

  task automatic idle_inputs();
    set_enq(1'b0, {$bits(cdb_packet_t){1'b0}});
    bus.CDB_grant_in = 1'b0;
    squash = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++;
    if ({bus.CDB_valid_out, bus.enq_ready, bus.count} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL reset_status: got v=%b r=%b c=%0d exp v=0 r=1 c=0",
               bus.CDB_valid_out, bus.enq_ready, bus.count);
    end
    n_tests++;
    if (dut_head() !== {$bits(cdb_packet_t){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_fields: got %h exp 0", dut_head());
    end
  endtask

  task automatic test_stream();
    int exp_rob[3] = '{3, 5, 7};
    bus.CDB_grant_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_enq(1'b1, rand_pkt(exp_rob[k]));
      tick();
      n_tests++;
      if (bus.CDB_valid_out !== 1'b1 || bus.CDB_ROB_idx_out !== ROB_W'(exp_rob[k])) begin
        n_fail++;
        $display("FAIL stream_rob%0d: got v=%b rob=%0d exp v=1 rob=%0d",
                 k, bus.CDB_valid_out, bus.CDB_ROB_idx_out, exp_rob[k]);
      end
      n_tests++;
      if (dut_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL stream_head%0d: got %h exp %h", k, dut_head(), exp_head());
      end
    end
    set_enq(1'b0, cur_pkt);
    tick();
    bus.CDB_grant_in = 1'b0;
    n_tests++;
    if (bus.count !== CNT_W'(0) || bus.CDB_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got c=%0d v=%b exp c=0 v=0", bus.count, bus.CDB_valid_out);
    end
  endtask

  task automatic test_full();
    cdb_packet_t filled[4];
    bus.CDB_grant_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      filled[i] = rand_pkt(10 + i);
      set_enq(1'b1, filled[i]);
      tick();
    end
    n_tests++;
    if (bus.count !== CNT_W'(4) || bus.enq_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_status: got c=%0d r=%b exp c=4 r=0", bus.count, bus.enq_ready);
    end
    set_enq(1'b1, rand_pkt(20));
    tick();
    n_tests++;
    if (bus.count !== CNT_W'(4) || dut_head() !== filled[0]) begin
      n_fail++;
      $display("FAIL full_drop: got c=%0d head=%h exp c=4 head=%h", bus.count, dut_head(), filled[0]);
    end
    set_enq(1'b0, cur_pkt);
    bus.CDB_grant_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (dut_head() !== filled[i]) begin
        n_fail++;
        $display("FAIL full_order%0d: got %h exp %h", i, dut_head(), filled[i]);
      end
      tick();
      if (i == 0) begin
        n_tests++;
        if (bus.enq_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_ready_back: got %b exp 1", bus.enq_ready);
        end
      end
    end
    bus.CDB_grant_in = 1'b0;
    n_tests++;
    if (bus.count !== CNT_W'(0)) begin
      n_fail++;
      $display("FAIL full_empty: got c=%0d exp 0", bus.count);
    end
  endtask

  task automatic test_full_simul();
    cdb_packet_t filled[4];
    bus.CDB_grant_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      filled[i] = rand_pkt(i);
      set_enq(1'b1, filled[i]);
      tick();
    end
    set_enq(1'b1, rand_pkt(30));
    bus.CDB_grant_in = 1'b1;
    tick();
    n_tests++;
    if (bus.count !== CNT_W'(3) || dut_head() !== filled[1]) begin
      n_fail++;
      $display("FAIL full_simul: got c=%0d head=%h exp c=3 head=%h", bus.count, dut_head(), filled[1]);
    end
    set_enq(1'b0, cur_pkt);
    for (int i = 2; i < 4; i++) begin
      tick();
      n_tests++;
      if (dut_head() !== filled[i]) begin
        n_fail++;
        $display("FAIL full_simul_order%0d: got %h exp %h", i, dut_head(), filled[i]);
      end
    end
    tick();
    bus.CDB_grant_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.CDB_grant_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_enq(1'b1, rand_pkt(i));
      tick();
    end
    bus.CDB_grant_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_enq(1'b1, rand_pkt(i + 2));
      tick();
      n_tests++;
      if (bus.count !== CNT_W'(2) || dut_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL b2b_%0d: got c=%0d head=%h exp c=2 head=%h", i, bus.count, dut_head(), exp_head());
      end
    end
    set_enq(1'b0, cur_pkt);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (dut_head() !== exp_head() || bus.count !== CNT_W'(mq.size())) begin
        n_fail++;
        $display("FAIL b2b_drain%0d: got c=%0d head=%h exp c=%0d head=%h",
                 i, bus.count, dut_head(), mq.size(), exp_head());
      end
    end
    bus.CDB_grant_in = 1'b0;
  endtask

  task automatic test_squash();
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, rand_pkt(i + 8));
      tick();
    end
    set_enq(1'b1, rand_pkt(15));
    bus.CDB_grant_in = 1'b1;
    squash = 1'b1;
    tick();
    squash = 1'b0;
    set_enq(1'b0, cur_pkt);
    bus.CDB_grant_in = 1'b0;
    n_tests++;
    if ({bus.CDB_valid_out, bus.enq_ready, bus.count} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL squash_status: got v=%b r=%b c=%0d exp v=0 r=1 c=0",
               bus.CDB_valid_out, bus.enq_ready, bus.count);
    end
    n_tests++;
    if (dut_head() !== {$bits(cdb_packet_t){1'b0}}) begin
      n_fail++;
      $display("FAIL squash_fields: got %h exp 0", dut_head());
    end
  endtask

  task automatic test_grant_empty();
    int p0;
    p0 = proto_err;
    bus.CDB_grant_in = 1'b1;
    tick();
    bus.CDB_grant_in = 1'b0;
    n_tests++;
    if (bus.count !== CNT_W'(0) || bus.CDB_valid_out !== 1'b0 || proto_err != p0 + 1) begin
      n_fail++;
      $display("FAIL grant_empty: got c=%0d v=%b perr=%0d exp c=0 v=0 perr=%0d",
               bus.count, bus.CDB_valid_out, proto_err, p0 + 1);
    end
    set_enq(1'b1, rand_pkt(21));
    tick();
    set_enq(1'b0, cur_pkt);
    n_tests++;
    if (dut_head() !== exp_head() || bus.count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL grant_empty_after: got c=%0d head=%h exp c=1 head=%h",
               bus.count, dut_head(), exp_head());
    end
    squash = 1'b1;
    tick();
    squash = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_enq($urandom_range(0, 2) != 0, rand_pkt($urandom_range(0, ROB - 1)));
      bus.CDB_grant_in = 1'($urandom_range(0, 1));
      squash = ($urandom_range(0, 40) == 0);
      reset  = ($urandom_range(0, 80) == 0);
      tick();
      n_tests++;
      if ({bus.CDB_valid_out, bus.enq_ready, bus.count} !== exp_status() || dut_head() !== exp_head()) begin
        n_fail++;
        $display("FAIL random_%0d: got v=%b r=%b c=%0d head=%h exp status=%b head=%h",
                 i, bus.CDB_valid_out, bus.enq_ready, bus.count, dut_head(), exp_status(), exp_head());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_full();
    test_full_simul();
    test_back_to_back();
    test_squash();
    test_grant_empty();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
